risc_core_datapath: RTL and testbench
=====================================

# risc_core_datapath

8-bit single-cycle datapath for the RISC core. It holds the program counter, the stack pointer and a 4×8 register file (`reg_file`), and performs arithmetic/logic in a combinational ALU (`alu`). The control unit drives it each cycle, and memory sits outside the block. It supplies the instruction address (`pc`), the data address/result (`alu_out`) and the store data (`mem_wr_data`).

## Interface
- Parameters: none (word width fixed at 8 via package type `word`).
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `rd`  in  2 (`e_reg`)  destination register; also ALU operand A and store-data source
- `rs`  in  2 (`e_reg`)  source register; ALU operand B when `alu_src`=0
- `imm`  in  8  immediate; ALU operand B when `alu_src`=1; jump target when `pc_src`=1
- `alu_op`  in  3 (`e_alu_op`)  ALU operation
- `alu_ex`  in  2 (`e_alu_ext_op`)  reserved extension op; no effect
- `reg_wr`  in  1  write register `rd` at the clock edge
- `pc_src`  in  1  1: next PC = `imm`
- `rimm`  in  1  instruction carries an immediate byte (PC step 2)
- `alu_src`  in  1  operand-B select
- `mem_to_reg`  in  1  register write data = `mem_data` instead of `alu_out`
- `mem_data`  in  8  memory read data
- `sp_wr`  in  1  stack operation this cycle
- `mem_sp`  in  1  stack direction: 0 push, 1 pop
- `pc`  out  8  program counter
- `alu_out`  out  8  ALU result or stack address
- `mem_wr_data`  out  8  store data, equal to R[`rd`]
- `alu_zero`  out  1  ALU result == 0

## Operation
- Register file:
  - Registers ra=0, rb=1, rc=2, re=3, all writable.
  - Two combinational read ports: R[`rd`] and R[`rs`].
  - One write port: R[`rd`] ← wd at posedge when `reg_wr`=1.
  - wd = `mem_to_reg` ? `mem_data` : `alu_out`.
- ALU:
  - A = R[`rd`]; B = `alu_src` ? `imm` : R[`rs`].
  - Ops: ALU_CPY=0 (B), ALU_ADD=1 (A+B), ALU_SUB=2 (A−B), ALU_AND=3, ALU_OR=4, ALU_XOR=5, ALU_SHL=6 (A<<B[2:0]), ALU_SHR=7 (logical A>>B[2:0]).
  - All results are mod 256; no carry or overflow out.
  - `alu_zero` reflects the ALU result, not `alu_out`.
- Output mux: `alu_out` = `sp_wr` ? (`mem_sp` ? sp+1 : sp) : ALU result.
- Stack: when `sp_wr`=1, sp ← `mem_sp` ? sp+1 : sp−1.
  - Push: address = sp, then sp is decremented.
  - Pop: address = sp+1, and sp becomes sp+1.
- PC: next = `pc_src` ? `imm` : pc + (`rimm` ? 2 : 1). Updates every cycle, mod 256.
- `mem_wr_data` = R[`rd`], combinational.

## Timing
- Reset (`rst`=0, asynchronous):
  - pc=0x00, sp=0xFF, all registers 0x00.
  - Held in reset while low; the first update is at the first rising edge after `rst` goes high.
  - Reset mid-operation aborts any pending write.
- All outputs are combinational from current state and inputs; state updates with zero-cycle latency at the edge.
- Read-during-write: a read of the register being written returns the old value until the edge.
- Wrap-around:
  - pc 0xFF+1 → 0x00; pc 0xFE+2 → 0x00.
  - sp 0x00 push → 0xFF; sp 0xFF pop → 0x00, with address 0x00.
- Simultaneous `sp_wr` and `reg_wr` with `mem_to_reg`=0 writes the stack address into R[`rd`]. This is legal.

## Structure
- `risc_pkg`: `word` (logic[7:0]) and `e_reg` (ra, rb, rc, re).
- `alu_pkg`: `e_alu_op` and `e_alu_ext_op`.
- Sub-modules: `reg_file` (ports: clk, rst, ra1, ra2, rd1, rd2, wa, wd, we) and `alu` (a, b, op, r, zero).
- PC, SP and the muxes stay in the top module.

## Test plan
- Reset: after reset, pc=0x00; one idle cycle with `rimm`=0 gives pc=0x01. Registers are 0, so R[ra] on `mem_wr_data` is 0x00.
- Register load: `mem_to_reg`=1, `reg_wr`=1, writing ra=0x7A, rb=0x8A, rc=0x9A, re=0xFD on successive cycles. Select each as `rd`: `mem_wr_data` reads 0x7A, 0x8A, 0x9A, 0xFD.
- ALU:
  - ADD ra,rb gives `alu_out`=0x04 with `alu_zero`=0.
  - SUB rb,rb gives 0x00 with `alu_zero`=1.
  - CPY with `alu_src`=1, `imm`=0x55 gives 0x55, written to rc.
- PC: `rimm`=1 steps +2; `pc_src`=1 with `imm`=0x40 gives pc=0x40 next cycle. From pc=0xFF, +1 wraps to 0x00.
- Stack:
  - Push gives `alu_out`=0xFF, then sp=0xFE.
  - A following pop gives `alu_out`=0xFF and sp=0xFF.
  - Push from sp=0x00 wraps to 0xFF.
- Asynchronous reset asserted mid-cycle during a `reg_wr`: pc, sp and registers clear immediately, and the write is lost.

Source files
------------

// File: rtl/risc_core_datapath_pkg.sv
// -----------------------------------------------------------------------------
// risc_core_datapath_pkg.sv
// Shared types for the RISC core datapath.
//   risc_pkg : machine word, register names, reset values of PC/SP.
//   alu_pkg  : ALU operation codes and the reserved extension-op field.
// No ports (packages only).
// -----------------------------------------------------------------------------
package risc_pkg;

  typedef logic [7:0] word;

  // Architectural registers, encoded as their register-file index.
  typedef enum logic [1:0] {
    ra = 2'd0,
    rb = 2'd1,
    rc = 2'd2,
    re = 2'd3
  } e_reg;

  localparam int  NUM_REGS = 4;
  localparam word PC_RESET = 8'h00;
  localparam word SP_RESET = 8'hFF;  // stack grows downward from the top of memory

endpackage : risc_pkg

package alu_pkg;

  typedef enum logic [2:0] {
    ALU_CPY = 3'd0,  // r = b
    ALU_ADD = 3'd1,  // r = a + b
    ALU_SUB = 3'd2,  // r = a - b
    ALU_AND = 3'd3,
    ALU_OR  = 3'd4,
    ALU_XOR = 3'd5,
    ALU_SHL = 3'd6,  // r = a << b[2:0]
    ALU_SHR = 3'd7   // r = a >> b[2:0], zero fill
  } e_alu_op;

  // Reserved for future ALU extensions; the current datapath ignores it.
  typedef enum logic [1:0] {
    ALU_EXT_NONE = 2'd0,
    ALU_EXT_1    = 2'd1,
    ALU_EXT_2    = 2'd2,
    ALU_EXT_3    = 2'd3
  } e_alu_ext_op;

endpackage : alu_pkg

// File: rtl/risc_core_datapath_if.sv
// -----------------------------------------------------------------------------
// risc_core_datapath_if.sv
// Control/status bundle between the control unit (master) and the datapath
// (slave).
//   Control (master -> slave): rd, rs, imm, alu_op, alu_ex, reg_wr, pc_src,
//     rimm, alu_src, mem_to_reg, mem_data, sp_wr, mem_sp
//   Status  (slave -> master): pc, alu_out, mem_wr_data, alu_zero
// -----------------------------------------------------------------------------
interface risc_core_datapath_if;
  import risc_pkg::*;
  import alu_pkg::*;

  // control unit -> datapath
  e_reg        rd;          // destination / operand A / store-data register
  e_reg        rs;          // source / operand B register
  word         imm;         // immediate or jump target
  e_alu_op     alu_op;
  e_alu_ext_op alu_ex;      // reserved
  logic        reg_wr;      // write R[rd] at the clock edge
  logic        pc_src;      // 1: jump to imm
  logic        rimm;        // instruction is two bytes long
  logic        alu_src;     // 1: operand B = imm
  logic        mem_to_reg;  // 1: register write data = mem_data
  word         mem_data;    // memory read data
  logic        sp_wr;       // stack operation this cycle
  logic        mem_sp;      // 0 push, 1 pop

  // datapath -> control unit / memory
  word         pc;
  word         alu_out;
  word         mem_wr_data;
  logic        alu_zero;

  modport master (
    output rd, rs, imm, alu_op, alu_ex, reg_wr, pc_src, rimm, alu_src,
           mem_to_reg, mem_data, sp_wr, mem_sp,
    input  pc, alu_out, mem_wr_data, alu_zero
  );

  modport slave (
    input  rd, rs, imm, alu_op, alu_ex, reg_wr, pc_src, rimm, alu_src,
           mem_to_reg, mem_data, sp_wr, mem_sp,
    output pc, alu_out, mem_wr_data, alu_zero
  );

endinterface : risc_core_datapath_if

// File: rtl/risc_core_datapath_alu.sv
// -----------------------------------------------------------------------------
// risc_core_datapath_alu.sv  (module alu)
// Combinational 8-bit ALU. All results wrap mod 256; no carry/overflow out.
//   a     in   operand A
//   b     in   operand B (shift amount is b[2:0])
//   op    in   operation (e_alu_op)
//   r     out  result
//   zero  out  r == 0
// -----------------------------------------------------------------------------
module alu
  import risc_pkg::*;
  import alu_pkg::*;
(
  input  word     a,
  input  word     b,
  input  e_alu_op op,
  output word     r,
  output logic    zero
);

  always_comb begin
    r = '0;
    case (op)
      ALU_CPY: r = b;
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_SHL: r = a << b[2:0];
      ALU_SHR: r = a >> b[2:0];
      default: r = '0;
    endcase
  end

  assign zero = (r == '0);

endmodule : alu

// File: rtl/risc_core_datapath_reg_file.sv
// -----------------------------------------------------------------------------
// risc_core_datapath_reg_file.sv  (module reg_file)
// 4 x 8 register file: two combinational read ports, one write port.
//   clk  in   rising-edge clock
//   rst  in   asynchronous active-low reset, clears all registers
//   ra1  in   read address 1      rd1 out  R[ra1]
//   ra2  in   read address 2      rd2 out  R[ra2]
//   wa   in   write address       wd  in   write data
//   we   in   write enable, sampled at the rising edge
// Reads are asynchronous, so a register being written still reads its old
// value until the edge.
// -----------------------------------------------------------------------------
module reg_file
  import risc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  e_reg ra1,
  input  e_reg ra2,
  output word  rd1,
  output word  rd2,
  input  e_reg wa,
  input  word  wd,
  input  logic we
);

  word r_regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (we) begin
      r_regs[wa] <= wd;
    end
  end

  assign rd1 = r_regs[ra1];
  assign rd2 = r_regs[ra2];

endmodule : reg_file

// File: rtl/risc_core_datapath.sv
// -----------------------------------------------------------------------------
// risc_core_datapath.sv
// Single-cycle 8-bit datapath of the RISC core: program counter, stack
// pointer, register file, ALU and the operand/result muxes.
//   clk  in     rising-edge clock
//   rst  in     asynchronous active-low reset (pc=0x00, sp=0xFF, regs=0)
//   bus  slave  control inputs from the control unit, and the outputs
//               pc, alu_out (ALU result or stack address), mem_wr_data
//               (= R[rd]) and alu_zero (ALU result == 0)
// All outputs are combinational from current state and inputs.
// -----------------------------------------------------------------------------
module risc_core_datapath
  import risc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  risc_core_datapath_if.slave   bus
);

  word  r_pc;
  word  r_sp;

  word  w_rd_data;
  word  w_rs_data;
  word  w_alu_b;
  word  w_alu_result;
  logic w_alu_zero;
  word  w_sp_inc;
  word  w_sp_dec;
  word  w_stack_addr;
  word  w_alu_out;
  word  w_wr_data;
  word  w_pc_step;
  word  w_pc_next;
  word  w_sp_next;
  logic w_unused_alu_ex;

  // The extension op is carried on the bus for future use only.
  assign w_unused_alu_ex = ^bus.alu_ex;

  // ---------------------------------------------------------------------------
  // Register file: port 1 serves rd (operand A, store data, write target),
  // port 2 serves rs (operand B).
  // ---------------------------------------------------------------------------
  reg_file u_reg_file (
    .clk (clk),
    .rst (rst),
    .ra1 (bus.rd),
    .ra2 (bus.rs),
    .rd1 (w_rd_data),
    .rd2 (w_rs_data),
    .wa  (bus.rd),
    .wd  (w_wr_data),
    .we  (bus.reg_wr)
  );

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  assign w_alu_b = bus.alu_src ? bus.imm : w_rs_data;

  alu u_alu (
    .a    (w_rd_data),
    .b    (w_alu_b),
    .op   (bus.alu_op),
    .r    (w_alu_result),
    .zero (w_alu_zero)
  );

  // ---------------------------------------------------------------------------
  // Stack: sp points at the next free slot. A push stores at sp and then
  // decrements; a pop pre-increments and reads from the new sp, so the pop
  // address and the updated sp are the same value.
  // ---------------------------------------------------------------------------
  assign w_sp_inc     = r_sp + 8'd1;
  assign w_sp_dec     = r_sp - 8'd1;
  assign w_stack_addr = bus.mem_sp ? w_sp_inc : r_sp;
  assign w_sp_next    = bus.sp_wr ? (bus.mem_sp ? w_sp_inc : w_sp_dec) : r_sp;

  // The stack address shares the alu_out bus, so a stack op combined with a
  // register write (mem_to_reg=0) deposits the stack address into R[rd].
  assign w_alu_out = bus.sp_wr ? w_stack_addr : w_alu_result;
  assign w_wr_data = bus.mem_to_reg ? bus.mem_data : w_alu_out;

  // ---------------------------------------------------------------------------
  // Program counter: advances every cycle, by 2 when an immediate byte follows.
  // ---------------------------------------------------------------------------
  assign w_pc_step = bus.rimm ? 8'd2 : 8'd1;
  assign w_pc_next = bus.pc_src ? bus.imm : (r_pc + w_pc_step);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= PC_RESET;
      r_sp <= SP_RESET;
    end else begin
      r_pc <= w_pc_next;
      r_sp <= w_sp_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.pc          = r_pc;
  assign bus.alu_out     = w_alu_out;
  assign bus.mem_wr_data = w_rd_data;
  assign bus.alu_zero    = w_alu_zero;

endmodule : risc_core_datapath

// File: tb/tb_risc_core_datapath.sv
// -----------------------------------------------------------------------------
// tb_risc_core_datapath.sv
// Self-checking bench: directed scenarios followed by random stimulus, all
// compared against an integer-arithmetic reference model of the datapath.
// -----------------------------------------------------------------------------
module tb_risc_core_datapath;
  import risc_pkg::*;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_checks = 0;
  int n_bad    = 0;

  // Reference model state
  int m_regs [4];
  int m_pc;
  int m_sp;

  word load_vals [4];
  int  stk_pop   [6];
  int  stk_addr  [6];

  risc_core_datapath_if dp_if ();

  risc_core_datapath dut (
    .clk (clk),
    .rst (rst),
    .bus (dp_if)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%02h exp=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    dp_if.rd         = ra;
    dp_if.rs         = ra;
    dp_if.imm        = 8'h00;
    dp_if.alu_op     = ALU_CPY;
    dp_if.alu_ex     = ALU_EXT_NONE;
    dp_if.reg_wr     = 1'b0;
    dp_if.pc_src     = 1'b0;
    dp_if.rimm       = 1'b0;
    dp_if.alu_src    = 1'b0;
    dp_if.mem_to_reg = 1'b0;
    dp_if.mem_data   = 8'h00;
    dp_if.sp_wr      = 1'b0;
    dp_if.mem_sp     = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    m_pc = 0;
    m_sp = 255;
  endtask

  function automatic int alu_ref(input int op, input int a, input int b);
    case (op)
      0: return b;
      1: return (a + b) % 256;
      2: return (a - b + 256) % 256;
      3: return a & b;
      4: return a | b;
      5: return a ^ b;
      6: return (a * (1 << (b % 8))) % 256;
      7: return a / (1 << (b % 8));
      default: return 0;
    endcase
  endfunction

  // Called just after a falling edge with inputs applied: checks every
  // output against the model, advances the model, returns at next falling edge.
  task automatic run_cycle(input string tag);
    int a, b, res, addr, out, wd, rd_i;
    #1;
    rd_i = int'(dp_if.rd);
    a    = m_regs[rd_i];
    b    = dp_if.alu_src ? int'(dp_if.imm) : m_regs[int'(dp_if.rs)];
    res  = alu_ref(int'(dp_if.alu_op), a, b);
    addr = dp_if.mem_sp ? (m_sp + 1) % 256 : m_sp;
    out  = dp_if.sp_wr ? addr : res;
    wd   = dp_if.mem_to_reg ? int'(dp_if.mem_data) : out;
    check_val({tag, ".pc"},          int'(dp_if.pc),          m_pc);
    check_val({tag, ".alu_out"},     int'(dp_if.alu_out),     out);
    check_val({tag, ".alu_zero"},    int'(dp_if.alu_zero),    (res == 0) ? 1 : 0);
    check_val({tag, ".mem_wr_data"}, int'(dp_if.mem_wr_data), a);
    if (dp_if.reg_wr) m_regs[rd_i] = wd;
    if (dp_if.sp_wr)  m_sp = dp_if.mem_sp ? (m_sp + 1) % 256 : (m_sp + 255) % 256;
    m_pc = dp_if.pc_src ? int'(dp_if.imm) : (m_pc + (dp_if.rimm ? 2 : 1)) % 256;
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    dp_if.rd         = e_reg'($urandom_range(0, 3));
    dp_if.rs         = e_reg'($urandom_range(0, 3));
    dp_if.imm        = word'($urandom_range(0, 255));
    dp_if.alu_op     = e_alu_op'($urandom_range(0, 7));
    dp_if.alu_ex     = e_alu_ext_op'($urandom_range(0, 3));
    dp_if.reg_wr     = 1'($urandom_range(0, 1));
    dp_if.pc_src     = ($urandom_range(0, 7) == 0);
    dp_if.rimm       = 1'($urandom_range(0, 1));
    dp_if.alu_src    = 1'($urandom_range(0, 1));
    dp_if.mem_to_reg = 1'($urandom_range(0, 1));
    dp_if.mem_data   = word'($urandom_range(0, 255));
    dp_if.sp_wr      = ($urandom_range(0, 3) == 0);
    dp_if.mem_sp     = 1'($urandom_range(0, 1));
  endtask

  initial begin
    load_vals = '{8'h7A, 8'h8A, 8'h9A, 8'hFD};
    // push/pop walk across the 0x00/0xFF boundary: direction, expected address
    stk_pop   = '{0, 1, 1, 0, 0, 1};
    stk_addr  = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF};

    idle();
    model_reset();

    // ---------------- reset ----------------
    repeat (3) @(negedge clk);
    #1;
    check_val("rst.pc", int'(dp_if.pc), 0);
    check_val("rst.ra", int'(dp_if.mem_wr_data), 0);
    dp_if.sp_wr = 1'b1;
    #1;
    check_val("rst.sp", int'(dp_if.alu_out), 8'hFF);
    idle();
    @(negedge clk);
    rst = 1'b1;
    run_cycle("idle0");
    #1;
    check_val("idle.pc_step", int'(dp_if.pc), 1);

    // ---------------- register load ----------------
    for (int i = 0; i < 4; i++) begin
      idle();
      dp_if.rd         = e_reg'(i);
      dp_if.reg_wr     = 1'b1;
      dp_if.mem_to_reg = 1'b1;
      dp_if.mem_data   = load_vals[i];
      run_cycle("load");
    end
    for (int i = 0; i < 4; i++) begin
      idle();
      dp_if.rd = e_reg'(i);
      #1;
      check_val($sformatf("load.r%0d", i), int'(dp_if.mem_wr_data), int'(load_vals[i]));
      run_cycle("readback");
    end

    // ---------------- ALU ----------------
    idle();
    dp_if.rd = ra; dp_if.rs = rb; dp_if.alu_op = ALU_ADD;
    #1;
    check_val("add.out",  int'(dp_if.alu_out), 8'h04);
    check_val("add.zero", int'(dp_if.alu_zero), 0);
    run_cycle("add");

    idle();
    dp_if.rd = rb; dp_if.rs = rb; dp_if.alu_op = ALU_SUB;
    #1;
    check_val("sub.out",  int'(dp_if.alu_out), 8'h00);
    check_val("sub.zero", int'(dp_if.alu_zero), 1);
    run_cycle("sub");

    idle();
    dp_if.rd = rc; dp_if.alu_src = 1'b1; dp_if.imm = 8'h55; dp_if.reg_wr = 1'b1;
    #1;
    check_val("cpy.out", int'(dp_if.alu_out), 8'h55);
    run_cycle("cpy");
    idle();
    dp_if.rd = rc;
    #1;
    check_val("cpy.rc", int'(dp_if.mem_wr_data), 8'h55);
    run_cycle("cpy_rd");

    // ---------------- PC ----------------
    idle();
    dp_if.rimm = 1'b1;
    run_cycle("pc_rimm");
    idle();
    dp_if.pc_src = 1'b1; dp_if.imm = 8'h40;
    run_cycle("pc_jump");
    idle();
    #1;
    check_val("pc.jump40", int'(dp_if.pc), 8'h40);
    dp_if.pc_src = 1'b1; dp_if.imm = 8'hFF;
    run_cycle("pc_to_ff");
    idle();
    #1;
    check_val("pc.ff", int'(dp_if.pc), 8'hFF);
    run_cycle("pc_wrap1");
    #1;
    check_val("pc.wrap1", int'(dp_if.pc), 8'h00);
    dp_if.pc_src = 1'b1; dp_if.imm = 8'hFE;
    run_cycle("pc_to_fe");
    idle();
    dp_if.rimm = 1'b1;
    run_cycle("pc_wrap2");
    idle();
    #1;
    check_val("pc.wrap2", int'(dp_if.pc), 8'h00);

    // ---------------- stack ----------------
    for (int k = 0; k < 6; k++) begin
      idle();
      dp_if.sp_wr  = 1'b1;
      dp_if.mem_sp = 1'(stk_pop[k]);
      #1;
      check_val($sformatf("stack.%0d", k), int'(dp_if.alu_out), stk_addr[k]);
      run_cycle("stack");
    end

    // push with a simultaneous register write stores the stack address in re
    idle();
    dp_if.sp_wr = 1'b1; dp_if.reg_wr = 1'b1; dp_if.rd = re;
    run_cycle("push_wr");
    idle();
    dp_if.rd = re;
    #1;
    check_val("push_wr.re", int'(dp_if.mem_wr_data), 8'hFF);
    run_cycle("push_wr_rd");

    // ---------------- random ----------------
    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      run_cycle("rnd");
    end

    // ---------------- async reset mid-cycle ----------------
    idle();
    dp_if.rd = ra; dp_if.reg_wr = 1'b1; dp_if.mem_to_reg = 1'b1; dp_if.mem_data = 8'h5C;
    run_cycle("pre_rst");
    idle();
    dp_if.rd = ra;
    #1;
    check_val("pre_rst.ra", int'(dp_if.mem_wr_data), 8'h5C);
    dp_if.reg_wr = 1'b1; dp_if.mem_to_reg = 1'b1; dp_if.mem_data = 8'h33;
    dp_if.sp_wr  = 1'b1; dp_if.mem_sp = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check_val("arst.pc", int'(dp_if.pc), 0);
    check_val("arst.ra", int'(dp_if.mem_wr_data), 0);
    check_val("arst.sp", int'(dp_if.alu_out), 8'hFF);
    @(posedge clk);
    #1;
    check_val("arst.wr_lost", int'(dp_if.mem_wr_data), 0);
    check_val("arst.pc_hold", int'(dp_if.pc), 0);
    @(negedge clk);
    idle();
    model_reset();
    rst = 1'b1;
    run_cycle("post_rst0");
    run_cycle("post_rst1");

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule : tb_risc_core_datapath
